// File: rtl/soc_data_mem_tester.sv
// Write-then-readback memory tester driving an Avalon-MM master port.
// Readback and compare are compiled in only with SOC_DATA_MEM_TESTER_READBACK_EN.
module soc_data_mem_tester #(
  parameter int ADDR_W       = 15,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
    S_RDWAIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [15:0]       r_len;
  logic [15:0]       r_idx;
  logic [31:0]       r_seed;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cs;
  logic              r_wr;
  logic              r_rd;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [15:0]       w_next_idx;
  logic              w_last;

  assign w_next_idx = r_idx + 16'd1;
  assign w_last     = (r_idx == r_len - 16'd1);

`ifdef SOC_DATA_MEM_TESTER_READBACK_EN
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  logic [LAT_W-1:0]  r_wait_cnt;
  logic              r_error;
  logic [15:0]       r_err_count;
  assign error     = r_error;
  assign err_count = r_err_count;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{avm_readdata, 32'(READ_LATENCY)};
  assign error     = 1'b0;
  assign err_count = 16'h0000;
`endif

  assign busy           = r_busy;
  assign done           = r_done;
  assign avm_address    = r_addr;
  assign avm_chipselect = r_cs;
  assign avm_write      = r_wr;
  assign avm_read       = r_rd;
  assign avm_byteenable = r_be;
  assign avm_writedata  = r_wdata;

  // Control FSM; every bus output is registered so it holds steady under waitrequest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_len   <= 16'h0000;
      r_idx   <= 16'h0000;
      r_seed  <= 32'h0000_0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0000_0000;
`ifdef SOC_DATA_MEM_TESTER_READBACK_EN
      r_wait_cnt  <= '0;
      r_error     <= 1'b0;
      r_err_count <= 16'h0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base <= base_addr;
            r_len  <= length;
            r_seed <= seed;
            r_idx  <= 16'h0000;
            r_busy <= 1'b1;
`ifdef SOC_DATA_MEM_TESTER_READBACK_EN
            r_error     <= 1'b0;
            r_err_count <= 16'h0000;
`endif
            if (length == 16'h0000) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WRITE;
              r_cs    <= 1'b1;
              r_wr    <= 1'b1;
              r_be    <= 4'hF;
              r_addr  <= base_addr;
              r_wdata <= seed;
            end
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            if (w_last) begin
              r_idx   <= 16'h0000;
              r_wr    <= 1'b0;
              r_wdata <= 32'h0000_0000;
`ifdef SOC_DATA_MEM_TESTER_READBACK_EN
              r_state <= S_READ;
              r_rd    <= 1'b1;
              r_addr  <= r_base;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_cs    <= 1'b0;
              r_be    <= 4'h0;
              r_addr  <= '0;
`endif
            end else begin
              r_idx   <= w_next_idx;
              r_addr  <= r_base + ADDR_W'(w_next_idx);
              r_wdata <= r_seed + 32'(w_next_idx);
            end
          end
        end
`ifdef SOC_DATA_MEM_TESTER_READBACK_EN
        S_READ: begin
          if (!avm_waitrequest) begin
            r_state    <= S_RDWAIT;
            r_cs       <= 1'b0;
            r_rd       <= 1'b0;
            r_be       <= 4'h0;
            r_addr     <= '0;
            r_wait_cnt <= LAT_W'(READ_LATENCY - 1);
          end
        end
        S_RDWAIT: begin
          if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end else begin
            if (avm_readdata != r_seed + 32'(r_idx)) begin
              r_error <= 1'b1;
              if (r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
              end
            end
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_idx   <= 16'h0000;
            end else begin
              r_state <= S_READ;
              r_idx   <= w_next_idx;
              r_cs    <= 1'b1;
              r_rd    <= 1'b1;
              r_be    <= 4'hF;
              r_addr  <= r_base + ADDR_W'(w_next_idx);
            end
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_cs    <= 1'b0;
          r_wr    <= 1'b0;
          r_rd    <= 1'b0;
          r_be    <= 4'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_data_mem_tester.sv
// Scoreboard bench for soc_data_mem_tester with a stallable zero-wait memory model.
`timescale 1ns/1ps
module tb_soc_data_mem_tester;

  localparam int AW = 15;
`ifdef SOC_DATA_MEM_TESTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   length = 16'h0;
  logic [31:0]   seed = 32'h0;
  logic          busy, done, error;
  logic [15:0]   err_count;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_write, avm_read;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic          avm_waitrequest;

  always #5 clk = ~clk;

  soc_data_mem_tester #(.ADDR_W(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .busy(busy), .done(done), .error(error),
    .err_count(err_count), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory model: single-cycle accept, one-clock read latency, optional stall and corruption.
  logic [31:0]   mem [0:(1<<AW)-1];
  int            stall_total = 0;
  int            stall_used  = 0;
  logic [AW-1:0] stall_addr  = '0;
  bit            corrupt_en  = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  assign avm_waitrequest = (stall_used < stall_total) && avm_chipselect && avm_write &&
                           (avm_address == stall_addr);

  always @(posedge clk) begin
    if (avm_waitrequest) stall_used <= stall_used + 1;
    if (avm_chipselect && !avm_waitrequest) begin
      if (avm_write) mem[avm_address] <= avm_writedata;
      if (avm_read)  avm_readdata <= mem[avm_address] ^
                       ((corrupt_en && avm_address == corrupt_addr) ? 32'h1 : 32'h0);
    end
  end

  // Monitor: bus invariants, hold-under-stall, scoreboard pop on each accepted access.
  acc_t          exp_q[$];
  int            cyc = 0;
  int            done_cnt = 0, last_acc_cyc = 0, last_done_cyc = 0, hold_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_wdata;
  logic          prev_wr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    acc_t e;
    if (!reset) begin
      chk("byteenable", 32'(avm_byteenable), avm_chipselect ? 32'hF : 32'h0);
      chk("wr_rd_excl", 32'(avm_write & avm_read), 32'h0);
      if (prev_stall) begin
        chk("hold_addr", 32'(avm_address), 32'(prev_addr));
        chk("hold_wdata", avm_writedata, prev_wdata);
        chk("hold_write", 32'(avm_write), 32'(prev_wr));
      end
      if (avm_chipselect && avm_write && avm_address == stall_addr) hold_cnt++;
      if (avm_chipselect && !avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", 32'(avm_address), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("acc_write", 32'(avm_write), 32'(e.wr));
          chk("acc_read", 32'(avm_read), 32'(!e.wr));
          chk("acc_addr", 32'(avm_address), 32'(e.addr));
          if (e.wr) chk("acc_wdata", avm_writedata, e.data);
        end
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        chk("busy_in_done", 32'(busy), 32'h1);
      end
      prev_stall = avm_chipselect && avm_waitrequest;
      prev_addr  = avm_address;
      prev_wdata = avm_writedata;
      prev_wr    = avm_write;
    end else begin
      prev_stall = 1'b0;
      exp_q.delete();
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_error"}, 32'(error), 32'h0);
    chk({tag, "_errcnt"}, 32'(err_count), 32'h0);
    chk({tag, "_cs"}, 32'(avm_chipselect), 32'h0);
    chk({tag, "_write"}, 32'(avm_write), 32'h0);
    chk({tag, "_read"}, 32'(avm_read), 32'h0);
    chk({tag, "_addr"}, 32'(avm_address), 32'h0);
    chk({tag, "_be"}, 32'(avm_byteenable), 32'h0);
    chk({tag, "_wdata"}, avm_writedata, 32'h0);
  endtask

  task automatic push_run(input logic [AW-1:0] b, input logic [15:0] n, input logic [31:0] s);
    acc_t e;
    for (int i = 0; i < int'(n); i++) begin
      e.wr = 1'b1; e.addr = b + AW'(i); e.data = s + 32'(i);
      exp_q.push_back(e);
    end
    if (RB) begin
      for (int i = 0; i < int'(n); i++) begin
        e.wr = 1'b0; e.addr = b + AW'(i); e.data = 32'h0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run(input string tag, input logic [AW-1:0] b, input logic [15:0] n,
                     input logic [31:0] s, input int exp_err, input int glitch_at);
    int d0, start_cyc, dcyc, acyc, exp_dcyc;
    bit got_done;
    d0 = done_cnt;
    got_done = 1'b0;
    dcyc = 0;
    acyc = 0;
    base_addr = b; length = n; seed = s;
    push_run(b, n, s);
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done_cnt != d0) begin
        got_done = 1'b1; dcyc = last_done_cyc; acyc = last_acc_cyc;
        break;
      end
      start = (k == glitch_at);
      if (k == glitch_at) base_addr = b + AW'(100);
      step();
    end
    chk({tag, "_done_seen"}, 32'(got_done), 32'h1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    exp_dcyc = (n == 16'h0) ? start_cyc + 1 : acyc + (RB ? 2 : 1);
    if (got_done) chk({tag, "_done_cycle"}, 32'(dcyc), 32'(exp_dcyc));
    chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'h1);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'h0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'h0);
    chk({tag, "_error"}, 32'(error), (RB && exp_err > 0) ? 32'h1 : 32'h0);
    chk({tag, "_errcnt"}, 32'(err_count), RB ? 32'(exp_err) : 32'h0);
  endtask

  initial begin
    int h0, d0;
    bit seen;
    repeat (3) step();
    chk_zero("reset");
    reset = 1'b0;
    step();
    chk("post_reset_cs", 32'(avm_chipselect), 32'h0);

    run("fill", AW'(16'h0010), 16'd4, 32'hA5A5_0000, 0, -1);

    stall_addr  = AW'(16'h0011);
    h0          = hold_cnt;
    stall_total = stall_used + 3;
    run("stall", AW'(16'h0010), 16'd4, 32'hA5A5_0000, 0, -1);
    chk("stall_hold_cycles", 32'(hold_cnt - h0), 32'h4);
    stall_addr = AW'(16'h1234);

    corrupt_en   = 1'b1;
    corrupt_addr = AW'(16'h0000);
    run("wrap", AW'(16'h7FFE), 16'd4, 32'h1357_9BDF, 1, -1);
    corrupt_en = 1'b0;

    d0 = done_cnt;
    base_addr = AW'(16'h0020); length = 16'd8; seed = 32'hCAFE_0000;
    push_run(AW'(16'h0020), 16'd8, 32'hCAFE_0000);
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (avm_chipselect && avm_write && avm_address == AW'(16'h0022)) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("midrun_reached_idx2", 32'(seen), 32'h1);
    reset = 1'b1;
    #1;
    chk_zero("midrun_reset");
    step();
    reset = 1'b0;
    step();
    chk("midrun_first_clk_cs", 32'(avm_chipselect), 32'h0);
    chk("midrun_no_done", 32'(done_cnt - d0), 32'h0);
    run("after_reset", AW'(16'h0030), 16'd5, 32'h0BAD_F00D, 0, -1);

    run("len0", AW'(16'h0040), 16'd0, 32'h1111_1111, 0, -1);
    run("glitch", AW'(16'h0050), 16'd6, 32'hFFFF_FFFE, 0, 3);
    run("len3", AW'(16'h0060), 16'd3, 32'h0000_0100, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_data_mem_tester.md
SOC_DATA_MEM_TESTER -- requirements
Module: soc_data_mem_tester

Interface
REQ-001 The module SHALL take parameter ADDR_W, default 15, as the word-address width of the target memory.
REQ-002 The module SHALL take parameter READ_LATENCY, default 1, as the fixed number of clocks from read acceptance to valid avm_readdata.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  input  1  sole clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled in IDLE only.
- base_addr  input  ADDR_W  first word address of the run.
- length  input  16  number of words in the run.
- seed  input  32  pattern seed; word i carries seed+i, mod 2^32.
- busy  output  1  high from the cycle after start is accepted until the end of DONE.
- done  output  1  one-cycle pulse at the end of a run.
- error  output  1  sticky mismatch flag for the current run.
- err_count  output  16  mismatch count, saturating at 16'hFFFF.
- avm_address  output  ADDR_W  word address.
- avm_chipselect  output  1  access strobe.
- avm_write  output  1  write request.
- avm_read  output  1  read request.
- avm_byteenable  output  4  byte lanes; 4'hF whenever chipselect is high, 4'h0 otherwise.
- avm_writedata  output  32  write data.
- avm_readdata  input  32  read data, valid READ_LATENCY clocks after acceptance.
- avm_waitrequest  input  1  slave stall; a request is accepted in a cycle where waitrequest is low.

Function
REQ-004 The FSM SHALL have the states IDLE, WRITE, READ, RDWAIT and DONE, and SHALL be encoded in registers only.
REQ-005 In IDLE with start=1, the block SHALL latch base_addr, length and seed, clear idx, err_count and error, and enter WRITE; if length=0 it SHALL enter DONE instead, with no bus traffic.
REQ-006 In WRITE, the block SHALL drive chipselect=1, write=1, address=(base+idx) mod 2^ADDR_W and writedata=seed+idx.
REQ-007 In WRITE, all avm outputs SHALL stay stable while waitrequest=1.
REQ-008 On write acceptance, idx SHALL increment; after acceptance of word length-1, idx SHALL clear and the FSM SHALL enter READ (or DONE when readback is compiled out).
REQ-009 In READ, the block SHALL drive chipselect=1, read=1 and address=(base+idx) mod 2^ADDR_W; on acceptance it SHALL enter RDWAIT with chipselect and read low.
REQ-010 RDWAIT SHALL last exactly READ_LATENCY clocks; on its last clock avm_readdata SHALL be compared with seed+idx.
REQ-011 On a mismatch, err_count SHALL increment (saturating) and error SHALL set.
REQ-012 After the RDWAIT compare, idx SHALL increment, and the FSM SHALL return to READ, or enter DONE after word length-1.
REQ-013 Only one access SHALL be outstanding at a time; write and read SHALL never be high together.
REQ-014 The address SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-015 DONE SHALL last one clock with done=1 and busy=1, then the FSM SHALL return to IDLE; error and err_count SHALL hold until the next accepted start.
REQ-016 start SHALL be ignored outside IDLE, including in the DONE cycle.

Reset
REQ-017 Reset assertion SHALL force, at any time including mid-transfer, state=IDLE and idx=0, with busy, done, error, err_count, avm_chipselect, avm_write, avm_read, avm_address, avm_byteenable and avm_writedata all 0.
REQ-018 No access SHALL be issued in the first clock after reset deassertion.

Configuration
REQ-019 With macro SOC_DATA_MEM_TESTER_READBACK_EN defined, the READ and RDWAIT states and the compare logic SHALL be compiled in.
REQ-020 Without SOC_DATA_MEM_TESTER_READBACK_EN, the block SHALL go WRITE->DONE, never assert avm_read, and hold error=0 and err_count=0.

Verification
REQ-021 Fill run: base=0x0010, length=4, seed=0xA5A50000, no stalls, zero-wait memory model -> writes of 0xA5A50000..0xA5A50003 to 0x10..0x13, then 4 reads; done pulses once, error=0, err_count=0.
REQ-022 Stall hold: waitrequest held high 3 cycles on write idx=1 -> address 0x11 and data 0xA5A50001 stay stable for 4 cycles; exactly 4 writes occur.
REQ-023 Wrap and fault: base=0x7FFE, length=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; model corrupts the read at 0x0000 -> err_count=1, error=1.
REQ-024 Reset mid-run: reset asserted during write idx=2 of length=8 -> all outputs 0 in the same cycle; a new start runs cleanly.
REQ-025 Edge cases: length=0 -> done on the cycle after start, no chipselect; start pulsed while busy -> ignored, with a single done.
REQ-026 Build without SOC_DATA_MEM_TESTER_READBACK_EN, length=3 -> 3 writes, avm_read never high, done 1 cycle after the last write is accepted.
